// File: rtl/pd_switch_sequencer_if.sv
// Power-domain sequencer bus: PMU level request plus the per-segment switch-ring handshake.
// The slave side is the sequencer; the master side is the PMU and switch ring.
interface pd_switch_sequencer_if #(
  parameter int N_STAGES = 3
);
  logic                power_i;
  logic [N_STAGES-1:0] enable_PD_ack_i;
  logic [N_STAGES-1:0] enable_PD_send_o;
  logic                rstn_o;
  logic                isolate_o;
  logic                clk_en_o;
  logic                done_o;
  logic                timeout_err_o;

  modport slave (
    input  power_i, enable_PD_ack_i,
    output enable_PD_send_o, rstn_o, isolate_o, clk_en_o, done_o, timeout_err_o
  );

  modport master (
    output power_i, enable_PD_ack_i,
    input  enable_PD_send_o, rstn_o, isolate_o, clk_en_o, done_o, timeout_err_o
  );
endinterface

// File: rtl/pd_switch_sequencer.sv
// Per-domain power-gate sequencer: ramps the switch ring and orders clock/isolation/reset around it.
// Optional ack watchdog enabled by defining PD_SEQ_ACK_TIMEOUT_EN.
module pd_switch_sequencer #(
  parameter int N_STAGES      = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  pd_switch_sequencer_if.slave    bus
);
  localparam int KW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_STAGES - 1);

  typedef enum logic [3:0] {
    S_OFF, S_SW_ON, S_SETTLE, S_CLK_ON, S_ISO_OFF,
    S_ON, S_CLK_OFF, S_ISO_ON, S_RST_ON, S_SW_OFF
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [N_STAGES-1:0] send_q, send_d;
  logic                rstn_q, rstn_d;
  logic                iso_q, iso_d;
  logic                clken_q, clken_d;
  logic                err_q, err_d;

  logic waiting, ack_ok, expired, go;

  // Down-ramp waits for the ack to fall, up-ramp for it to rise; level sensitive, so stale acks pass.
  assign waiting = (state_q == S_SW_ON) || (state_q == S_SW_OFF);
  assign ack_ok  = (state_q == S_SW_OFF) ? !bus.enable_PD_ack_i[k_q] : bus.enable_PD_ack_i[k_q];
  assign go      = ack_ok || expired;

`ifdef PD_SEQ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;

  assign expired = waiting && !ack_ok && (tcnt_q == TW'(ACK_TIMEOUT - 1));

  // Any advance leaves or re-enters a wait state, so the count restarts per segment.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)                                tcnt_q <= '0;
    else if (waiting && !ack_ok && !expired)    tcnt_q <= tcnt_q + 1'b1;
    else                                        tcnt_q <= '0;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    scnt_d  = scnt_q;
    send_d  = send_q;
    rstn_d  = rstn_q;
    iso_d   = iso_q;
    clken_d = clken_q;
    err_d   = err_q;
    unique case (state_q)
      S_OFF: if (bus.power_i) begin
        state_d   = S_SW_ON;
        k_d       = '0;
        send_d[0] = 1'b1;
      end
      S_SW_ON: if (go) begin
        if (!ack_ok) err_d = 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_SETTLE;
          scnt_d  = SW'(SETTLE_CYCLES - 1);
        end else begin
          k_d         = k_q + 1'b1;
          send_d[k_d] = 1'b1;
        end
      end
      S_SETTLE: if (scnt_q == '0) begin
        state_d = S_CLK_ON;
        clken_d = 1'b1;
      end else begin
        scnt_d = scnt_q - 1'b1;
      end
      S_CLK_ON:  begin state_d = S_ISO_OFF; iso_d  = 1'b0; end
      S_ISO_OFF: begin state_d = S_ON;      rstn_d = 1'b1; end
      S_ON: if (!bus.power_i) begin
        state_d = S_CLK_OFF;
        clken_d = 1'b0;
      end
      S_CLK_OFF: begin state_d = S_ISO_ON; iso_d  = 1'b1; end
      S_ISO_ON:  begin state_d = S_RST_ON; rstn_d = 1'b0; end
      S_RST_ON: begin
        state_d        = S_SW_OFF;
        k_d            = K_LAST;
        send_d[K_LAST] = 1'b0;
      end
      S_SW_OFF: if (go) begin
        if (!ack_ok) err_d = 1'b1;
        if (k_q == '0) begin
          state_d = S_OFF;
        end else begin
          k_d         = k_q - 1'b1;
          send_d[k_d] = 1'b0;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_OFF;
      k_q     <= '0;
      scnt_q  <= '0;
      send_q  <= '0;
      rstn_q  <= 1'b0;
      iso_q   <= 1'b1;
      clken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      scnt_q  <= scnt_d;
      send_q  <= send_d;
      rstn_q  <= rstn_d;
      iso_q   <= iso_d;
      clken_q <= clken_d;
      err_q   <= err_d;
    end
  end

  assign bus.enable_PD_send_o = send_q;
  assign bus.rstn_o           = rstn_q;
  assign bus.isolate_o        = iso_q;
  assign bus.clk_en_o         = clken_q;
  assign bus.timeout_err_o    = err_q;
  assign bus.done_o           = ((state_q == S_ON)  &&  bus.power_i) ||
                                ((state_q == S_OFF) && !bus.power_i);
endmodule

// File: tb/tb_pd_switch_sequencer.sv
// Directed bench for pd_switch_sequencer: per-edge vector table for a full up/down cycle,
// plus hand sequences for ack stall, mid-sequence request pulse, reset and ack timeout.
module tb_pd_switch_sequencer;
  localparam int N = 3;
`ifdef PD_SEQ_ACK_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] hold0 = '0;

  always #5 clk = ~clk;

  pd_switch_sequencer_if #(.N_STAGES(N)) bus();
  assign bus.enable_PD_ack_i = bus.enable_PD_send_o & ~hold0;

  pd_switch_sequencer #(.N_STAGES(N), .SETTLE_CYCLES(4), .ACK_TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  typedef struct {
    logic         power;
    logic [N-1:0] send;
    logic         clk_en;
    logic         iso;
    logic         rstn;
    logic         done;
  } vec_t;

  vec_t vecs[18];
  int   tests = 0;
  int   fails = 0;

  // {send, clk_en, isolate, rstn, done, timeout_err}
  function automatic logic [7:0] outs();
    return {bus.enable_PD_send_o, bus.clk_en_o, bus.isolate_o, bus.rstn_o,
            bus.done_o, bus.timeout_err_o};
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (send,clk_en,iso,rstn,done,terr)", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_done;
    logic stuck_ok;

    //          pwr  send    clk iso rst done
    vecs[0]  = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};

    bus.power_i = 1'b0;
    repeat (3) step();
    chk("reset_state", outs(), 8'b000_0_1_0_1_0);
    bus.power_i = 1'b1;
    #1;
    chk("reset_done_follows_power", outs(), 8'b000_0_1_0_0_0);
    rstn = 1'b1;

    // Loopback up/down cycle, one vector per edge.
    for (int i = 0; i < 18; i++) begin
      bus.power_i = vecs[i].power;
      step();
      chk($sformatf("vec%0d", i + 1), outs(),
          {vecs[i].send, vecs[i].clk_en, vecs[i].iso, vecs[i].rstn, vecs[i].done, 1'b0});
    end

    // ack[1] held low for 20 extra cycles during power-up.
    bus.power_i = 1'b1;
    hold0       = 3'b010;
    first_done  = 0;
    stuck_ok    = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      if (e == 23) hold0 = '0;
      step();
      if (e >= 2 && e <= 22 && bus.enable_PD_send_o !== 3'b011) stuck_ok = 1'b0;
      if (bus.done_o === 1'b1 && first_done == 0) first_done = e;
    end
    chki("stall_send_held_011", int'(stuck_ok), 1);
    chki("stall_done_edge", first_done, 30);
    bus.power_i = 1'b0;
    repeat (7) step();
    chk("stall_back_off", outs(), 8'b000_0_1_0_1_0);

    // Request pulses low mid-ramp, then drops for good before ON is reached.
    for (int e = 1; e <= 17; e++) begin
      bus.power_i = (e == 3 || e == 4 || e >= 9) ? 1'b0 : 1'b1;
      step();
      if (e == 4)  chk("pulse_ramp_continues", outs(), 8'b111_0_1_0_0_0);
      if (e == 10) chk("pulse_reaches_on",     outs(), 8'b111_1_0_1_0_0);
      if (e == 16) chk("pulse_ring_cleared",   outs(), 8'b000_0_1_0_0_0);
      if (e == 17) chk("pulse_back_off",       outs(), 8'b000_0_1_0_1_0);
    end

    // Reset asserted mid power-up.
    bus.power_i = 1'b1;
    repeat (9) step();
    chk("pre_reset_iso_off", outs(), 8'b111_1_0_0_0_0);
    rstn        = 1'b0;
    bus.power_i = 1'b0;
    step();
    chk("mid_reset", outs(), 8'b000_0_1_0_1_0);
    rstn = 1'b1;
    step();

`ifdef PD_SEQ_ACK_TIMEOUT_EN
    // ack[2] stuck low: watchdog forces SETTLE after 8 cycles in SW_ON[2].
    bus.power_i = 1'b1;
    hold0       = 3'b100;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 10) chk("to_still_waiting", outs(), 8'b111_0_1_0_0_0);
      if (e == 11) chk("to_fired",         outs(), 8'b111_0_1_0_0_1);
      if (e == 14) chk("to_settling",      outs(), 8'b111_0_1_0_0_1);
      if (e == 15) chk("to_clk_on",        outs(), 8'b111_1_1_0_0_1);
      if (e == 17) chk("to_on",            outs(), 8'b111_1_0_1_1_1);
    end
    hold0       = '0;
    bus.power_i = 1'b0;
    repeat (7) step();
    chk("to_err_sticky", outs(), 8'b000_0_1_0_1_1);
    rstn = 1'b0;
    step();
    chk("to_err_cleared", outs(), 8'b000_0_1_0_1_0);
    rstn = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pd_switch_sequencer.md
Name: pd_switch_sequencer

Overview:
- Per-domain power-gate sequencer under the PMU power-down FSM.
- Takes that FSM's level power request and drives the domain's daisy-chained power-switch ring (send/ack per stage).
- Orders clock enable, isolation and domain reset around the switch ramp.
- Reports completion on done_o, which the PMU FSM waits on before advancing.

Parameters:
N_STAGES, 3, number of switch-ring segments (send/ack pairs), >=1
SETTLE_CYCLES, 4, cycles to wait after last ack before enabling clock, >=1
ACK_TIMEOUT, 255, max cycles waiting on one ack (only with timeout feature), >=1

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
power_i  in  1  requested domain state: 1=on, 0=off
enable_PD_ack_i  in  N_STAGES  ack returned per switch segment
enable_PD_send_o  out  N_STAGES  enable per switch segment
rstn_o  out  1  domain reset, active-low
isolate_o  out  1  output isolation, active-high
clk_en_o  out  1  domain clock enable
done_o  out  1  domain settled in requested state
timeout_err_o  out  1  sticky ack-timeout flag

Behaviour:
- Interface: one clock (clk_i); reset rstn_i is synchronous and active-low, sampled on the clk_i rising edge only.
- Reset values:
  - State OFF; send=0, rstn_o=0, isolate_o=1, clk_en_o=0, timeout_err_o=0.
  - done_o follows its formula, i.e. equals !power_i.
- All outputs except done_o are registered.
- done_o is combinational: (state==ON & power_i) | (state==OFF & !power_i).
- States: OFF, SW_ON[k], SETTLE, CLK_ON, ISO_OFF, ON, CLK_OFF, ISO_ON, RST_ON, SW_OFF[k]. k is a stage-index register of width clog2(N_STAGES), min 1.
- Power-up:
  - OFF and power_i=1 -> SW_ON[0], setting send[0].
  - SW_ON[k]: hold until ack[k] is sampled 1. Then, if k<N_STAGES-1, go to SW_ON[k+1] and set send[k+1]; else go to SETTLE.
  - SETTLE: stays exactly SETTLE_CYCLES cycles (down-counter loaded on entry), then CLK_ON with clk_en_o=1.
  - CLK_ON -> ISO_OFF with isolate_o=0.
  - ISO_OFF -> ON with rstn_o=1.
- Power-down:
  - ON and power_i=0 -> CLK_OFF with clk_en_o=0.
  - CLK_OFF -> ISO_ON with isolate_o=1.
  - ISO_ON -> RST_ON with rstn_o=0.
  - RST_ON -> SW_OFF[N_STAGES-1], clearing that send bit.
  - SW_OFF[k]: hold until ack[k] is sampled 0. Then, if k>0, go to SW_OFF[k-1] and clear send[k-1]; else go to OFF.
- Request changes mid-sequence: power_i is ignored outside OFF/ON. A sequence always completes before the new level is acted on.
  - Example: power_i drops during SW_ON[1]; the unit finishes to ON, then starts power-down on the next edge.
- Send bits change only one at a time. Ring order is 0..N-1 on power-up and N-1..0 on power-down.
- Stale acks: an ack already at the required level on state entry advances on the next edge. No edge detection.
- Reset mid-sequence: all outputs return to reset values on the next edge, abruptly switching the domain off.
- Latency with combinational loopback ack=send, N=3, SETTLE=4:
  - Power-up: done_o rises 10 edges after the edge sampling power_i=1.
  - Power-down: done_o rises 7 edges after the edge sampling power_i=0.

Optional Feature:
Macro PD_SEQ_ACK_TIMEOUT_EN.
- Defined:
  - A per-wait counter (width clog2(ACK_TIMEOUT+1)) clears on entering each SW_ON/SW_OFF state.
  - When it reaches ACK_TIMEOUT with the ack still not at the required level, the FSM advances as if the ack arrived.
  - timeout_err_o is set and stays set until reset.
- Not defined:
  - No counter; the FSM waits indefinitely.
  - timeout_err_o is tied 0.

Test Plan:
- Reset, power_i=0, ack looped to send -> send=000, rstn_o=0, isolate_o=1, clk_en_o=0, done_o=1; after power_i=1, done_o=0.
- Loopback, power_i 0->1 -> send 001,011,111 on edges 1-3; clk_en_o=1 edge 8; isolate_o=0 edge 9; rstn_o=1 and done_o=1 edge 10.
- From ON, power_i 1->0 -> clk_en_o=0 edge 1; isolate_o=1 edge 2; rstn_o=0 edge 3; send 011,001,000 on edges 4-6; done_o=1 edge 7.
- Ack[1] held 0 for 20 cycles during power-up -> send stays 011 for those cycles; sequence resumes one edge after ack[1]=1; done_o delayed by 20 cycles.
- power_i pulsed 0 for 2 cycles during SW_ON[1] -> reaches ON (done_o stays 0 there since power_i=0 when sampled), then full power-down to OFF with done_o=1.
- PD_SEQ_ACK_TIMEOUT_EN, ACK_TIMEOUT=8, ack[2] stuck 0 -> SETTLE entered after 8 cycles in SW_ON[2]; timeout_err_o=1 and held until rstn_i=0.
